// File: rtl/monty_reduce_iter.sv
// monty_reduce_iter: word-serial Montgomery reduction engine.
// Computes C = X * 2^-(W*ITER) mod q for q = qH*2^W + 1, W = LOGQ - LOGQH,
// one W-bit reduction step per cycle. Result satisfies C < 2q.
// Build macro MONTY_REDUCE_FINAL_CORR_EN adds a final conditional
// subtraction state so that C < q (one extra cycle of latency).
//
// state | meaning
// IDLE  | waiting for X, in_ready high
// RUN   | one W-bit reduction step per cycle, cnt counts steps
// CORR  | C = (A < q) ? A : A - q   (macro build only)
// DONE  | result held on C with out_valid until out_ready

module monty_reduce_iter #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 17,
  parameter int LOGC  = LOGQ + 1,
  parameter int ITER  = 2,
  parameter int LOGX  = 2 * LOGQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGX-1:0]  X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGC-1:0]  C,
  output logic             busy
);

  localparam int W     = LOGQ - LOGQH;
  localparam int AW    = LOGX + 1;
  localparam int MW    = W + LOGQH;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [LOGQH-1:0] qh_q, qh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LOGC-1:0]  c_q, c_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     lo;
  logic [W-1:0]     m;
  logic [MW-1:0]    mq;
  logic [AW-1:0]    a_step;

  // One reduction step: (A + m*q) / 2^W, rewritten with q = qH*2^W + 1 so the
  // low word never has to be added explicitly (lo + m is 0 or exactly 2^W).
  always_comb begin
    lo     = a_q[W-1:0];
    m      = {W{1'b0}} - lo;
    mq     = {{LOGQH{1'b0}}, m} * {{W{1'b0}}, qh_q};
    a_step = (a_q >> W)
           + {{(AW-MW){1'b0}}, mq}
           + {{(AW-1){1'b0}}, (lo != {W{1'b0}})};
  end

`ifdef MONTY_REDUCE_FINAL_CORR_EN
  logic [LOGC:0]   diff;
  logic [LOGC-1:0] c_corr;

  // Subtract q once; a borrow out of the top bit means A was already below q.
  always_comb begin
    diff   = {1'b0, a_q[LOGC-1:0]}
           - {{(LOGC+1-LOGQ){1'b0}}, qh_q, {(W-1){1'b0}}, 1'b1};
    c_corr = diff[LOGC] ? a_q[LOGC-1:0] : diff[LOGC-1:0];
  end
`endif

  // Next-state, datapath register updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    qh_d        = qh_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) begin
          a_d     = {1'b0, X};
          qh_d    = qH;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        a_d   = a_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef MONTY_REDUCE_FINAL_CORR_EN
          state_d = CORR;
`else
          c_d         = a_step[LOGC-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
`endif
        end
      end
`ifdef MONTY_REDUCE_FINAL_CORR_EN
      CORR: begin
        busy        = 1'b1;
        c_d         = c_corr;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      qh_q        <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      qh_q        <= qh_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign C         = c_q;

endmodule

// File: tb/tb_monty_reduce_iter.sv
// Self-checking bench for monty_reduce_iter (qH-parameterised Montgomery
// reduction, W=47, ITER=2). Reference model works from the Montgomery
// definition: C = (X + M*q) / 2^94 with M = -X*q^-1 mod 2^94.
module tb_monty_reduce_iter;

  localparam int LOGQ  = 64;
  localparam int LOGQH = 17;
  localparam int LOGC  = 65;
  localparam int ITER  = 2;
  localparam int LOGX  = 128;
`ifdef MONTY_REDUCE_FINAL_CORR_EN
  localparam int LAT      = ITER + 1;
  localparam bit CORR_ON  = 1'b1;
`else
  localparam int LAT      = ITER;
  localparam bit CORR_ON  = 1'b0;
`endif
  localparam logic [16:0]  QH0 = 17'h1ABCD;
  localparam logic [127:0] Q0  = {64'd0, QH0, 47'd0} + 128'd1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [LOGQH-1:0] qH = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LOGX-1:0]  X = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LOGC-1:0]  C;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  monty_reduce_iter #(
    .LOGQ(LOGQ), .LOGQH(LOGQH), .LOGC(LOGC), .ITER(ITER), .LOGX(LOGX)
  ) dut (
    .clk(clk), .rst(rst), .qH(qH), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .out_valid(out_valid), .out_ready(out_ready), .C(C), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [16:0]  qh;
    logic [127:0] x;
    logic [64:0]  exp;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [255:0] q_of(input logic [16:0] qh);
    return ({239'd0, qh} << 47) + 256'd1;
  endfunction

  function automatic logic [64:0] ref_c(input logic [16:0] qh, input logic [127:0] x);
    logic [255:0] q, mask, inv, m, full, xw;
    q    = q_of(qh);
    mask = (256'd1 << 94) - 256'd1;
    xw   = {128'd0, x};
    inv  = 256'd1;
    for (int k = 0; k < 2; k++) inv = (inv * (256'd2 - q * inv)) & mask;
    m    = (256'd0 - xw * inv) & mask;
    full = (xw + m * q) >> 94;
    if (CORR_ON && full >= q) full = full - q;
    return full[64:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wait_in_ready();
    int g = 0;
    while (!in_ready && g < 100) begin tick(); g++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got=0 expected=1");
    end
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got=0 expected=1");
    end
  endtask

  task automatic run_job(input logic [16:0] qh, input logic [127:0] x, input int hold,
                         output logic [64:0] c_got, output int lat);
    qH = qh; X = x; in_valid = 1'b1;
    wait_in_ready();
    tick();
    in_valid = 1'b0;
    X  = {$urandom, $urandom, $urandom, $urandom};
    qH = 17'($urandom);
    wait_out_valid(lat);
    c_got = C;
    out_ready = 1'b0;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] rand_x(input logic [16:0] qh);
    logic [255:0] r, lim;
    r   = {128'd0, $urandom, $urandom, $urandom, $urandom};
    lim = q_of(qh) << 94;
    r   = r % lim;
    return r[127:0];
  endfunction

  initial begin
    logic [64:0]  c_got, c0;
    logic [127:0] x_t, bp_x;
    logic [255:0] bound;
    logic [16:0]  qh_t;
    int           lat, a1, a2;
    bit           seen;

    x_t = 128'd1 << 94;
    vecs[0] = '{"x_2p94",   QH0, x_t,           65'd1};
    vecs[1] = '{"x_q",      QH0, Q0,            CORR_ON ? 65'd0 : Q0[64:0]};
    vecs[2] = '{"x_zero",   QH0, 128'd0,        65'd0};
    vecs[3] = '{"x_qm1",    QH0, Q0 - 128'd1,   ref_c(QH0, Q0 - 128'd1)};
    vecs[4] = '{"x_allone", QH0, {128{1'b1}},   ref_c(QH0, {128{1'b1}})};

    // reset and idle
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", C, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_c", C, 0);
    chk("idle_busy", busy, 0);

    // table vectors
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].qh, vecs[i].x, 0, c_got, lat);
      chk({vecs[i].name, "_c"}, c_got, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, lat, LAT);
    end

    // back-to-back X=0 then X=q-1 with out_ready held high
    out_ready = 1'b1; qH = QH0; X = 128'd0; in_valid = 1'b1;
    wait_in_ready();
    tick(); a1 = cyc;
    X = Q0 - 128'd1;
    chk("b2b_busy", busy, 1);
    wait_out_valid(lat);
    chk("b2b_c0", C, 0);
    wait_in_ready();
    tick(); a2 = cyc;
    in_valid = 1'b0;
    chk("b2b_gap", a2 - a1, LAT + 2);
    wait_out_valid(lat);
    chk("b2b_c1", C, ref_c(QH0, Q0 - 128'd1));
    tick();
    out_ready = 1'b0;
    chk("b2b_drop", out_valid, 0);

    // backpressure with qH/in_valid activity while busy and while held
    bp_x = rand_x(QH0);
    qH = QH0; X = bp_x; in_valid = 1'b1;
    wait_in_ready();
    tick();
    in_valid = 1'b0; qH = ~QH0; X = {$urandom, $urandom, $urandom, $urandom};
    wait_out_valid(lat);
    chk("bp_lat", lat, LAT);
    c0 = C;
    chk("bp_c", c0, ref_c(QH0, bp_x));
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      qH = i[0] ? QH0 : ~QH0;
      in_valid = i[0];
      X = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("bp_hold", {out_valid, in_ready, C}, {1'b1, 1'b0, c0});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", out_valid, 0);
    chk("bp_no_accept", {busy, in_ready}, 2'b01);

    // reset in the middle of RUN
    qH = QH0; X = 128'd1 << 94; in_valid = 1'b1;
    wait_in_ready();
    tick();
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    seen = 1'b0;
    repeat (2) begin tick(); if (out_valid) seen = 1'b1; end
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b1;
    repeat (6) begin tick(); if (out_valid) seen = 1'b1; end
    chk("mid_no_result", seen, 0);
    chk("mid_idle", {busy, in_ready}, 2'b01);
    run_job(QH0, 128'd1 << 94, 0, c_got, lat);
    chk("mid_next_c", c_got, 1);
    chk("mid_next_lat", lat, LAT);

    // random sweep
    for (int n = 0; n < 10000; n++) begin
      qh_t  = 17'($urandom);
      x_t   = rand_x(qh_t);
      run_job(qh_t, x_t, int'($urandom_range(0, 2)), c_got, lat);
      bound = CORR_ON ? q_of(qh_t) : (q_of(qh_t) << 1);
      chk("rnd_c", c_got, ref_c(qh_t, x_t));
      chk("rnd_lat", lat, LAT);
      chk("rnd_bound", {255'd0, c_got} < bound, 1);
      if (errors > 100) break;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
